// File: rtl/byte_serializer.sv
// byte_serializer
// Sequences bytes into an 8:1 bit-select mux. The current byte sits on
// data_q (mux data inputs) and sel walks the eight bit positions, advancing
// once per accepted serial beat. A one-entry holding register lets the next
// byte queue up so consecutive bytes stream without an idle cycle.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : upstream byte handshake, in_data sampled on accept
//   ser_valid/ser_ready : serial beat handshake, bit is data_q[sel]
//   ser_last            : current bit is the final bit of the byte
//   data_q, sel         : mux data inputs and bit select
//   busy                : shifting, or a byte is waiting in the hold register
module byte_serializer #(
   parameter int MSB_FIRST = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       ser_ready,
   output logic       ser_valid,
   output logic       ser_last,
   output logic [7:0] data_q,
   output logic [2:0] sel,
   output logic       busy
);

   localparam logic [2:0] START = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
   localparam logic [2:0] LAST  = (MSB_FIRST != 0) ? 3'd0 : 3'd7;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   state_e     state_q;
   logic       hold_full_q;
   logic [7:0] hold_q;

   logic       accept;
   logic       xfer;
   logic       at_end;
   logic [2:0] sel_step;

   // in_ready depends only on the hold flop, so no combinational path
   // from in_valid or ser_ready reaches it.
   assign in_ready  = !hold_full_q;
   assign accept    = in_valid && in_ready;
   assign ser_valid = (state_q == SHIFT);
   assign xfer      = ser_valid && ser_ready;
   assign at_end    = (sel == LAST);
   assign ser_last  = ser_valid && at_end;
   assign busy      = ser_valid || hold_full_q;
   assign sel_step  = (MSB_FIRST != 0) ? (sel - 3'd1) : (sel + 3'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_full_q <= 1'b0;
         hold_q      <= 8'h00;
         data_q      <= 8'h00;
         sel         <= START;
      end else begin
         case (state_q)
            IDLE: begin
               // hold is always empty here: it is drained before leaving SHIFT
               if (accept) begin
                  data_q  <= in_data;
                  sel     <= START;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (xfer && at_end) begin
                  sel <= START;
                  if (hold_full_q) begin
                     data_q      <= hold_q;
                     hold_full_q <= 1'b0;
                  end else if (accept) begin
                     // final beat and a fresh byte together: skip the hold
                     data_q <= in_data;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  if (xfer) sel <= sel_step;
                  // accept implies hold empty, so hold is never overwritten
                  if (accept) begin
                     hold_q      <= in_data;
                     hold_full_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer. Two instances share all inputs:
// u_lsb (MSB_FIRST=0) and u_msb (MSB_FIRST=1). Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
module tb_byte_serializer;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       ser_ready;

   logic       in_ready0, ser_valid0, ser_last0, busy0;
   logic [7:0] data_q0;
   logic [2:0] sel0;
   logic       in_ready1, ser_valid1, ser_last1, busy1;
   logic [7:0] data_q1;
   logic [2:0] sel1;

   int checks = 0;
   int passes = 0;

   byte_serializer #(.MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .ser_ready(ser_ready), .ser_valid(ser_valid0),
      .ser_last(ser_last0), .data_q(data_q0), .sel(sel0), .busy(busy0)
   );

   byte_serializer #(.MSB_FIRST(1)) u_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .ser_ready(ser_ready), .ser_valid(ser_valid1),
      .ser_last(ser_last1), .data_q(data_q1), .sel(sel1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // flags = {ser_valid, ser_last, busy, in_ready}
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; ser_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({ser_valid0, ser_last0, busy0, in_ready0} !== 4'b0001 || data_q0 !== 8'h00 || sel0 !== 3'd0) begin
         $display("FAIL reset_lsb flags=%b data=%h sel=%0d exp flags=0001 data=00 sel=0",
                  {ser_valid0, ser_last0, busy0, in_ready0}, data_q0, sel0);
      end else passes++;
      checks++;
      if ({ser_valid1, ser_last1, busy1, in_ready1} !== 4'b0001 || data_q1 !== 8'h00 || sel1 !== 3'd7) begin
         $display("FAIL reset_msb flags=%b data=%h sel=%0d exp flags=0001 data=00 sel=7",
                  {ser_valid1, ser_last1, busy1, in_ready1}, data_q1, sel1);
      end else passes++;
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (ser_valid0 !== 1'b0 || data_q0 !== 8'h00) begin
         $display("FAIL reset_no_accept valid=%b data=%h exp valid=0 data=00", ser_valid0, data_q0);
      end else passes++;
   endtask

   task automatic test_lsb_first();
      logic [0:7] exp_bits = 8'b1010_0101;   // A5 bits in sel order 0..7
      in_valid = 1'b1; in_data = 8'hA5; ser_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (ser_valid0 !== 1'b1 || sel0 !== 3'(k) || data_q0[sel0] !== exp_bits[k] ||
             ser_last0 !== (k == 7)) begin
            $display("FAIL lsb_bit k=%0d valid=%b sel=%0d bit=%b last=%b exp valid=1 sel=%0d bit=%b last=%b",
                     k, ser_valid0, sel0, data_q0[sel0], ser_last0, k, exp_bits[k], (k == 7));
         end else passes++;
         @(negedge clk);
      end
      checks++;
      if (ser_valid0 !== 1'b0 || busy0 !== 1'b0 || sel0 !== 3'd0) begin
         $display("FAIL lsb_idle valid=%b busy=%b sel=%0d exp 0 0 0", ser_valid0, busy0, sel0);
      end else passes++;
   endtask

   task automatic test_msb_first();
      logic [0:7] exp_bits = 8'b1000_0001;   // 81 bits in sel order 7..0
      in_valid = 1'b1; in_data = 8'h81; ser_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (ser_valid1 !== 1'b1 || sel1 !== 3'(7 - k) || data_q1[sel1] !== exp_bits[k] ||
             ser_last1 !== (k == 7)) begin
            $display("FAIL msb_bit k=%0d valid=%b sel=%0d bit=%b last=%b exp valid=1 sel=%0d bit=%b last=%b",
                     k, ser_valid1, sel1, data_q1[sel1], ser_last1, 7 - k, exp_bits[k], (k == 7));
         end else passes++;
         @(negedge clk);
      end
      checks++;
      if (ser_valid1 !== 1'b0 || busy1 !== 1'b0 || sel1 !== 3'd7) begin
         $display("FAIL msb_idle valid=%b busy=%b sel=%0d exp 0 0 7", ser_valid1, busy1, sel1);
      end else passes++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_data;
      logic       exp_rdy;
      in_valid = 1'b1; in_data = 8'h0F; ser_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         exp_data = (k < 8) ? 8'h0F : 8'hF0;
         exp_rdy  = !(k >= 1 && k <= 7);
         checks++;
         if (ser_valid0 !== 1'b1 || sel0 !== 3'(k % 8) || data_q0 !== exp_data || in_ready0 !== exp_rdy) begin
            $display("FAIL b2b k=%0d valid=%b sel=%0d data=%h rdy=%b exp valid=1 sel=%0d data=%h rdy=%b",
                     k, ser_valid0, sel0, data_q0, in_ready0, k % 8, exp_data, exp_rdy);
         end else passes++;
         if (k == 0) in_data = 8'hF0;
         else in_valid = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (ser_valid0 !== 1'b0 || busy0 !== 1'b0) begin
         $display("FAIL b2b_idle valid=%b busy=%b exp 0 0", ser_valid0, busy0);
      end else passes++;
   endtask

   task automatic test_backpressure();
      logic [7:0]  bytes [3] = '{8'h3C, 8'hC3, 8'h5A};
      logic [31:0] pat = 32'b1011_0010_1110_0110_1001_1101_0011_0101;
      int          nacc = 0;
      int          nrx = 0;
      int          cyc = 0;
      logic        pv = 1'b0;
      logic        pr = 1'b0;
      logic [7:0]  pd = 8'h00;
      logic [2:0]  ps = 3'd0;
      logic        exp_bit;
      while (nrx < 24 && cyc < 400) begin
         // a stalled beat must leave the presented bit untouched
         if (pv && !pr) begin
            checks++;
            if (ser_valid0 !== 1'b1 || sel0 !== ps || data_q0 !== pd) begin
               $display("FAIL bp_stall cyc=%0d valid=%b sel=%0d data=%h exp valid=1 sel=%0d data=%h",
                        cyc, ser_valid0, sel0, data_q0, ps, pd);
            end else passes++;
         end
         ser_ready = pat[cyc % 32];
         in_valid  = (nacc < 3);
         in_data   = (nacc < 3) ? bytes[nacc] : 8'h00;
         if (in_valid && in_ready0) nacc++;
         if (ser_valid0 && ser_ready) begin
            exp_bit = bytes[nrx / 8][nrx % 8];
            checks++;
            if (sel0 !== 3'(nrx % 8) || data_q0[sel0] !== exp_bit) begin
               $display("FAIL bp_bit n=%0d sel=%0d bit=%b exp sel=%0d bit=%b",
                        nrx, sel0, data_q0[sel0], nrx % 8, exp_bit);
            end else passes++;
            nrx++;
         end
         pv = ser_valid0; pr = ser_ready; pd = data_q0; ps = sel0;
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0; ser_ready = 1'b1;
      checks++;
      if (nrx != 24 || nacc != 3) begin
         $display("FAIL bp_count bits=%0d accepts=%0d exp bits=24 accepts=3", nrx, nacc);
      end else passes++;
      checks++;
      if (ser_valid0 !== 1'b0 || busy0 !== 1'b0) begin
         $display("FAIL bp_idle valid=%b busy=%b exp 0 0", ser_valid0, busy0);
      end else passes++;
   endtask

   task automatic test_bypass();
      in_valid = 1'b1; in_data = 8'h11; ser_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      checks++;
      if (sel0 !== 3'd7 || busy0 !== 1'b1 || in_ready0 !== 1'b1) begin
         $display("FAIL bypass_pre sel=%0d busy=%b rdy=%b exp sel=7 busy=1 rdy=1", sel0, busy0, in_ready0);
      end else passes++;
      in_valid = 1'b1; in_data = 8'h96;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (data_q0 !== 8'h96 || sel0 !== 3'd0 || ser_valid0 !== 1'b1 || in_ready0 !== 1'b1) begin
         $display("FAIL bypass data=%h sel=%0d valid=%b rdy=%b exp data=96 sel=0 valid=1 rdy=1",
                  data_q0, sel0, ser_valid0, in_ready0);
      end else passes++;
      repeat (8) @(negedge clk);
      checks++;
      if (ser_valid0 !== 1'b0 || busy0 !== 1'b0) begin
         $display("FAIL bypass_idle valid=%b busy=%b exp 0 0", ser_valid0, busy0);
      end else passes++;
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; in_data = 8'hE7; ser_ready = 1'b1;
      @(negedge clk);
      in_data = 8'h42;                 // goes to hold on this edge
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (sel0 !== 3'd3 || in_ready0 !== 1'b0 || busy0 !== 1'b1 || data_q0 !== 8'hE7) begin
         $display("FAIL rstmid_pre sel=%0d rdy=%b busy=%b data=%h exp sel=3 rdy=0 busy=1 data=e7",
                  sel0, in_ready0, busy0, data_q0);
      end else passes++;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ser_valid0, ser_last0, busy0, in_ready0} !== 4'b0001 || data_q0 !== 8'h00 || sel0 !== 3'd0) begin
         $display("FAIL rstmid_async flags=%b data=%h sel=%0d exp flags=0001 data=00 sel=0",
                  {ser_valid0, ser_last0, busy0, in_ready0}, data_q0, sel0);
      end else passes++;
      checks++;
      if (sel1 !== 3'd7 || ser_valid1 !== 1'b0 || busy1 !== 1'b0) begin
         $display("FAIL rstmid_msb sel=%0d valid=%b busy=%b exp sel=7 valid=0 busy=0", sel1, ser_valid1, busy1);
      end else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (ser_valid0 !== 1'b0 || busy0 !== 1'b0) begin
            $display("FAIL rstmid_quiet k=%0d valid=%b busy=%b exp 0 0", k, ser_valid0, busy0);
         end else passes++;
      end
      in_valid = 1'b1; in_data = 8'h01;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (ser_valid0 !== 1'b1 || data_q0 !== 8'h01 || sel0 !== 3'd0 || in_ready0 !== 1'b1) begin
         $display("FAIL rstmid_resume valid=%b data=%h sel=%0d rdy=%b exp valid=1 data=01 sel=0 rdy=1",
                  ser_valid0, data_q0, sel0, in_ready0);
      end else passes++;
      repeat (8) @(negedge clk);
      checks++;
      if (ser_valid0 !== 1'b0 || busy0 !== 1'b0) begin
         $display("FAIL rstmid_idle valid=%b busy=%b exp 0 0", ser_valid0, busy0);
      end else passes++;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; ser_ready = 1'b0;
      test_reset();
      test_lsb_first();
      test_msb_first();
      test_back_to_back();
      test_backpressure();
      test_bypass();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
